// File: rtl/sync_merge_fifo_if.sv
// rtl/sync_merge_fifo_if.sv - channel-input / merged-output bundle of the merge FIFO
interface sync_merge_fifo_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 193,
  parameter int CNT_W = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*WIDTH-1:0] data_in;
  logic                 out_ready;
  logic                 clr_ovf;
  logic [WIDTH-1:0]     data_out;
  logic [CHW-1:0]       ch_out;
  logic [NCH-1:0]       fifo_empty;
  logic [NCH-1:0]       ovf_flag;
  logic [NCH*CNT_W-1:0] ovf_count;

  modport master (
    output data_in, out_ready, clr_ovf,
    input  data_out, ch_out, fifo_empty, ovf_flag, ovf_count
  );

  modport slave (
    input  data_in, out_ready, clr_ovf,
    output data_out, ch_out, fifo_empty, ovf_flag, ovf_count
  );
endinterface

// File: rtl/sync_merge_fifo.sv
// rtl/sync_merge_fifo.sv - per-channel FIFOs merged round-robin onto one valid-tagged stream
module sync_merge_fifo #(
  parameter int NCH         = 4,
  parameter int WIDTH       = 193,
  parameter int DEPTH       = 16,
  parameter int NSTAGES_IN  = 1,
  parameter int NSTAGES_OUT = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_merge_fifo_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = WIDTH - 1;
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0] in_pipe [NCH][NSTAGES_IN];
  logic [PW-1:0]    mem     [NCH][DEPTH];
  logic [AW-1:0]    wr_ptr  [NCH];
  logic [AW-1:0]    rd_ptr  [NCH];
  logic [AW:0]      cnt     [NCH];
  logic [CNT_W-1:0] ovf_cnt [NCH];
  logic [NCH-1:0]   ovf_flag_q;

  logic [CHW-1:0]   rr_ptr;
  logic [CHW-1:0]   grant_id;
  logic             grant_valid;
  logic [NCH-1:0]   push_req;
  logic [NCH-1:0]   pop;
  logic [NCH-1:0]   push_ok;
  logic [NCH-1:0]   drop;

  logic [WIDTH-1:0] out_pipe [NSTAGES_OUT];
  logic [CHW-1:0]   ch_pipe  [NSTAGES_OUT];

  // First non-empty channel at or after rr_ptr wins; only occupancy counts, so no bypass.
  always_comb begin : arb
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (bus.out_ready) begin
      for (int i = 0; i < NCH; i++) begin
        idx = (int'(rr_ptr) + i) % NCH;
        if (!grant_valid && cnt[idx] != '0) begin
          grant_valid = 1'b1;
          grant_id    = CHW'(idx);
        end
      end
    end
  end

  always_comb begin
    push_req = '0;
    pop      = '0;
    push_ok  = '0;
    drop     = '0;
    for (int c = 0; c < NCH; c++) begin
      push_req[c] = in_pipe[c][NSTAGES_IN-1][WIDTH-1];
      pop[c]      = grant_valid && (grant_id == CHW'(c));
      // A full FIFO still accepts when the same channel is being popped this cycle.
      push_ok[c]  = push_req[c] && ((cnt[c] != FULL_CNT) || pop[c]);
      drop[c]     = push_req[c] && (cnt[c] == FULL_CNT) && !pop[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push_ok[c]) begin
        mem[c][wr_ptr[c]] <= in_pipe[c][NSTAGES_IN-1][PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pipe    <= '{default: '0};
      wr_ptr     <= '{default: '0};
      rd_ptr     <= '{default: '0};
      cnt        <= '{default: '0};
      ovf_cnt    <= '{default: '0};
      ovf_flag_q <= '0;
      rr_ptr     <= '0;
      out_pipe   <= '{default: '0};
      ch_pipe    <= '{default: '0};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        in_pipe[c][0] <= bus.data_in[c*WIDTH +: WIDTH];
        for (int s = 1; s < NSTAGES_IN; s++) begin
          in_pipe[c][s] <= in_pipe[c][s-1];
        end
        if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])     rd_ptr[c] <= rd_ptr[c] + 1'b1;
        if (push_ok[c] && !pop[c])      cnt[c] <= cnt[c] + 1'b1;
        else if (!push_ok[c] && pop[c]) cnt[c] <= cnt[c] - 1'b1;
        // Clear takes priority so a drop in the clearing cycle is not recorded.
        if (bus.clr_ovf) begin
          ovf_flag_q[c] <= 1'b0;
          ovf_cnt[c]    <= '0;
        end else if (drop[c]) begin
          ovf_flag_q[c] <= 1'b1;
          if (ovf_cnt[c] != CNT_MAX) ovf_cnt[c] <= ovf_cnt[c] + 1'b1;
        end
      end

      if (grant_valid) begin
        rr_ptr      <= (grant_id == CHW'(NCH-1)) ? '0 : grant_id + 1'b1;
        out_pipe[0] <= {1'b1, mem[grant_id][rd_ptr[grant_id]]};
        ch_pipe[0]  <= grant_id;
      end else begin
        out_pipe[0] <= '0;
        ch_pipe[0]  <= '0;
      end
      for (int s = 1; s < NSTAGES_OUT; s++) begin
        out_pipe[s] <= out_pipe[s-1];
        ch_pipe[s]  <= ch_pipe[s-1];
      end
    end
  end

  always_comb begin
    bus.data_out   = out_pipe[NSTAGES_OUT-1];
    bus.ch_out     = ch_pipe[NSTAGES_OUT-1];
    bus.ovf_flag   = ovf_flag_q;
    bus.fifo_empty = '0;
    bus.ovf_count  = '0;
    for (int c = 0; c < NCH; c++) begin
      bus.fifo_empty[c]                 = (cnt[c] == '0);
      bus.ovf_count[c*CNT_W +: CNT_W]   = ovf_cnt[c];
    end
  end
endmodule
